// File: rtl/exec_flow_ctrl_if.sv
// Execute-stage flow-control bundle: decode/writeback handshakes,
// redirect, CSR and halt sideband.
interface exec_flow_ctrl_if #(
    parameter int COUNT_W = 32
);
    logic               i_dec_valid;
    logic               o_dec_ready;
    logic               o_ex_fire;
    logic               i_branch_taken;
    logic               i_jump;
    logic [31:0]        i_target;
    logic               i_is_csr;
    logic               i_is_sys;
    logic               o_wb_valid;
    logic               i_wb_ready;
    logic               o_redirect_valid;
    logic [31:0]        o_redirect_pc;
    logic               o_flush;
    logic               i_csr_done;
    logic               o_halted;
    logic               i_resume;
    logic [COUNT_W-1:0] o_retired;

    modport master (
        input  i_dec_valid,
        output o_dec_ready,
        output o_ex_fire,
        input  i_branch_taken,
        input  i_jump,
        input  i_target,
        input  i_is_csr,
        input  i_is_sys,
        output o_wb_valid,
        input  i_wb_ready,
        output o_redirect_valid,
        output o_redirect_pc,
        output o_flush,
        input  i_csr_done,
        output o_halted,
        input  i_resume,
        output o_retired
    );

    modport slave (
        output i_dec_valid,
        input  o_dec_ready,
        input  o_ex_fire,
        output i_branch_taken,
        output i_jump,
        output i_target,
        output i_is_csr,
        output i_is_sys,
        input  o_wb_valid,
        output i_wb_ready,
        input  o_redirect_valid,
        input  o_redirect_pc,
        input  o_flush,
        output i_csr_done,
        input  o_halted,
        output i_resume,
        input  o_retired
    );
endinterface

// File: rtl/exec_flow_ctrl.sv
// Execute-stage issue/retire controller: owns the EX valid bit,
// redirects on taken control flow, serialises CSRs and halts on ECALL/EBREAK.
module exec_flow_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int COUNT_W      = 32
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    exec_flow_ctrl_if.master   bus
);
    typedef enum logic [1:0] {
        RUN,
        FLUSH,
        CSR_WAIT,
        HALT
    } state_t;

    localparam logic [3:0]         FLUSH_LOAD = FLUSH_CYCLES[3:0];
    localparam logic [COUNT_W-1:0] ONE        = {{(COUNT_W-1){1'b0}}, 1'b1};

    state_t             state;
    logic               ex_valid;
    logic [3:0]         cnt;
    logic [COUNT_W-1:0] retired;

    logic in_run;
    logic wb_valid;
    logic retire;
    logic take;
    logic redir;
    logic sys;
    logic csr;
    logic ctl;
    logic dec_ready;
    logic fire;

    assign in_run    = (state == RUN);
    assign wb_valid  = ex_valid & in_run;
    assign retire    = wb_valid & bus.i_wb_ready;
    assign take      = bus.i_branch_taken | bus.i_jump;
    // Control events only count when the instruction actually retires.
    assign redir     = retire & take;
    assign sys       = retire & ~take & bus.i_is_sys;
    assign csr       = retire & ~take & ~bus.i_is_sys & bus.i_is_csr;
    assign ctl       = redir | sys | csr;
    assign dec_ready = in_run & (~ex_valid | (retire & ~ctl));
    assign fire      = bus.i_dec_valid & dec_ready;

    assign bus.o_dec_ready      = dec_ready;
    assign bus.o_ex_fire        = fire;
    assign bus.o_wb_valid       = wb_valid;
    assign bus.o_redirect_valid = redir;
    assign bus.o_redirect_pc    = bus.i_target & 32'hFFFF_FFFE;
    assign bus.o_flush          = redir | (state == FLUSH);
    assign bus.o_halted         = (state == HALT);
    assign bus.o_retired        = retired;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= RUN;
            ex_valid <= 1'b0;
            cnt      <= 4'd0;
            retired  <= '0;
        end else begin
            if (fire) begin
                ex_valid <= 1'b1;
            end else if (retire) begin
                ex_valid <= 1'b0;
            end
            if (retire) begin
                retired <= retired + ONE;
            end
            case (state)
                RUN: begin
                    unique case (1'b1)
                        redir: begin
                            state <= FLUSH;
                            cnt   <= FLUSH_LOAD;
                        end
                        sys:     state <= HALT;
                        csr:     state <= CSR_WAIT;
                        default: ;
                    endcase
                end
                FLUSH: begin
                    // Leave once the final counted flush cycle has been spent.
                    if (cnt <= 4'd1) begin
                        state <= RUN;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                CSR_WAIT: begin
                    if (bus.i_csr_done) begin
                        state <= RUN;
                    end
                end
                HALT: begin
                    if (bus.i_resume) begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_exec_flow_ctrl.sv
// Directed bench for exec_flow_ctrl: stream, branch, backpressure,
// CSR, halt, async reset and counter wrap.
module tb_exec_flow_ctrl;
    logic i_clk;
    logic i_rst_n;
    int   n_chk;
    int   n_err;

    exec_flow_ctrl_if #(.COUNT_W(32)) bus ();
    exec_flow_ctrl_if #(.COUNT_W(4))  sbus ();

    exec_flow_ctrl #(.FLUSH_CYCLES(2), .COUNT_W(32)) u_dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus.master)
    );

    exec_flow_ctrl #(.FLUSH_CYCLES(2), .COUNT_W(4)) u_small (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (sbus.master)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        i_rst_n = 1'b0;
        bus.i_dec_valid = 0;
        bus.i_branch_taken = 0;
        bus.i_jump = 0;
        bus.i_target = 32'h0;
        bus.i_is_csr = 0;
        bus.i_is_sys = 0;
        bus.i_wb_ready = 1;
        bus.i_csr_done = 0;
        bus.i_resume = 0;
        sbus.i_dec_valid = 0;
        sbus.i_branch_taken = 0;
        sbus.i_jump = 0;
        sbus.i_target = 32'h0;
        sbus.i_is_csr = 0;
        sbus.i_is_sys = 0;
        sbus.i_wb_ready = 1;
        sbus.i_csr_done = 0;
        sbus.i_resume = 0;

        #2;
        check("rst_wb_valid", bus.o_wb_valid, 0);
        check("rst_redirect", bus.o_redirect_valid, 0);
        check("rst_flush", bus.o_flush, 0);
        check("rst_halted", bus.o_halted, 0);
        check("rst_dec_ready", bus.o_dec_ready, 1);
        check("rst_retired", bus.o_retired, 0);
        #10 i_rst_n = 1'b1;
        cyc();

        // Stream of 5 instructions at one per cycle
        for (int i = 0; i < 6; i++) begin
            bus.i_dec_valid = (i < 5);
            settle();
            check("stream_dec_ready", bus.o_dec_ready, 1);
            check("stream_wb_valid", bus.o_wb_valid, (i > 0) ? 1 : 0);
            check("stream_flush", bus.o_flush, 0);
            cyc();
        end
        settle();
        check("stream_retired", bus.o_retired, 5);

        // Taken branch with odd target
        bus.i_dec_valid = 1;
        cyc();
        bus.i_dec_valid = 0;
        bus.i_branch_taken = 1;
        bus.i_target = 32'h0000_0105;
        settle();
        check("br_redirect_valid", bus.o_redirect_valid, 1);
        check("br_redirect_pc", bus.o_redirect_pc, 32'h0000_0104);
        check("br_flush0", bus.o_flush, 1);
        check("br_dec_ready0", bus.o_dec_ready, 0);
        cyc();
        bus.i_branch_taken = 0;
        bus.i_dec_valid = 1;
        for (int i = 0; i < 2; i++) begin
            settle();
            check("br_flush", bus.o_flush, 1);
            check("br_dec_ready", bus.o_dec_ready, 0);
            check("br_fire_ignored", bus.o_ex_fire, 0);
            check("br_redirect_once", bus.o_redirect_valid, 0);
            cyc();
        end
        bus.i_dec_valid = 0;
        settle();
        check("br_flush_end", bus.o_flush, 0);
        check("br_dec_ready_end", bus.o_dec_ready, 1);
        check("br_retired", bus.o_retired, 6);

        // JAL held by writeback backpressure
        bus.i_dec_valid = 1;
        cyc();
        bus.i_dec_valid = 0;
        bus.i_jump = 1;
        bus.i_target = 32'h0000_0200;
        bus.i_wb_ready = 0;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("bp_wb_valid", bus.o_wb_valid, 1);
            check("bp_no_redirect", bus.o_redirect_valid, 0);
            check("bp_dec_ready", bus.o_dec_ready, 0);
            cyc();
        end
        bus.i_wb_ready = 1;
        settle();
        check("bp_redirect", bus.o_redirect_valid, 1);
        check("bp_redirect_pc", bus.o_redirect_pc, 32'h0000_0200);
        cyc();
        bus.i_jump = 0;
        settle();
        check("bp_retired", bus.o_retired, 7);
        cyc();
        cyc();
        settle();
        check("bp_flush_end", bus.o_flush, 0);
        check("bp_dec_ready_end", bus.o_dec_ready, 1);

        // CSR serialisation; a done in the retire cycle is ignored
        bus.i_dec_valid = 1;
        cyc();
        bus.i_dec_valid = 0;
        bus.i_is_csr = 1;
        bus.i_csr_done = 1;
        settle();
        check("csr_wb_valid", bus.o_wb_valid, 1);
        check("csr_dec_ready_r", bus.o_dec_ready, 0);
        cyc();
        bus.i_is_csr = 0;
        bus.i_csr_done = 0;
        for (int i = 0; i < 3; i++) begin
            bus.i_csr_done = (i == 2);
            settle();
            check("csr_wait_dec_ready", bus.o_dec_ready, 0);
            check("csr_wait_wb_valid", bus.o_wb_valid, 0);
            cyc();
        end
        bus.i_csr_done = 0;
        bus.i_dec_valid = 1;
        settle();
        check("csr_accept_ready", bus.o_dec_ready, 1);
        check("csr_accept_fire", bus.o_ex_fire, 1);
        check("csr_retired", bus.o_retired, 8);
        cyc();
        bus.i_dec_valid = 0;
        settle();
        check("csr_next_wb_valid", bus.o_wb_valid, 1);
        cyc();
        settle();
        check("csr_next_retired", bus.o_retired, 9);

        // Halt; stray resume beforehand has no effect
        bus.i_resume = 1;
        settle();
        check("halt_stray_resume", bus.o_halted, 0);
        cyc();
        bus.i_resume = 0;
        bus.i_dec_valid = 1;
        cyc();
        bus.i_dec_valid = 0;
        bus.i_is_sys = 1;
        bus.i_is_csr = 1;
        settle();
        check("halt_no_redirect", bus.o_redirect_valid, 0);
        check("halt_no_flush", bus.o_flush, 0);
        check("halt_dec_ready_r", bus.o_dec_ready, 0);
        cyc();
        bus.i_is_sys = 0;
        bus.i_is_csr = 0;
        bus.i_csr_done = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("halt_halted", bus.o_halted, 1);
            check("halt_dec_ready", bus.o_dec_ready, 0);
            cyc();
        end
        bus.i_csr_done = 0;
        bus.i_resume = 1;
        settle();
        check("halt_resume_cycle", bus.o_halted, 1);
        cyc();
        bus.i_resume = 0;
        settle();
        check("halt_released", bus.o_halted, 0);
        check("halt_dec_ready_end", bus.o_dec_ready, 1);
        check("halt_retired", bus.o_retired, 10);

        // Async reset in the last counted flush cycle
        bus.i_dec_valid = 1;
        cyc();
        bus.i_dec_valid = 0;
        bus.i_branch_taken = 1;
        cyc();
        bus.i_branch_taken = 0;
        cyc();
        settle();
        check("arst_pre_flush", bus.o_flush, 1);
        i_rst_n = 1'b0;
        #1;
        check("arst_flush", bus.o_flush, 0);
        check("arst_retired", bus.o_retired, 0);
        check("arst_dec_ready", bus.o_dec_ready, 1);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        cyc();
        settle();
        check("arst_run_flush", bus.o_flush, 0);
        check("arst_run_ready", bus.o_dec_ready, 1);
        check("arst_run_wb", bus.o_wb_valid, 0);

        // 4-bit counter wraps after 16 retires
        sbus.i_dec_valid = 1;
        repeat (16) cyc();
        settle();
        check("wrap_15", sbus.o_retired, 4'hF);
        cyc();
        settle();
        check("wrap_0", sbus.o_retired, 4'h0);
        sbus.i_dec_valid = 0;
        cyc();
        settle();
        check("wrap_1", sbus.o_retired, 4'h1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/exec_flow_ctrl.md
Name: exec_flow_ctrl

Overview:
- Issue and retire controller for the execute stage of the RV32I core.
- Owns the EX-stage valid bit and performs the valid/ready handshake with decode (upstream) and writeback (downstream).
- On a taken branch or jump leaving execute, it redirects fetch and flushes younger instructions for a fixed number of cycles.
- Serialises CSR instructions until the CSR file acknowledges, and halts on ECALL/EBREAK until resumed.

Parameters:
- FLUSH_CYCLES, 2, number of cycles o_flush stays asserted after the redirect cycle; legal range 1..15.
- COUNT_W, 32, width of the retired-instruction counter.

Ports:
- i_clk  in  1  core clock
- i_rst_n  in  1  asynchronous active-low reset
- i_dec_valid  in  1  decode presents an instruction
- o_dec_ready  out  1  controller accepts the decode instruction this cycle
- o_ex_fire  out  1  load enable for the EX pipeline register; equals i_dec_valid & o_dec_ready
- i_branch_taken  in  1  execute branch_inst_wire for the instruction in EX
- i_jump  in  1  execute jump_inst_wire for the instruction in EX
- i_target  in  32  execute alu_result_2, the branch/jump target
- i_is_csr  in  1  EX instruction is CSRRW/CSRRS/CSRRC/CSRRWI/CSRRSI/CSRRCI
- i_is_sys  in  1  EX instruction is ECALL/EBREAK
- o_wb_valid  out  1  EX instruction offered to writeback
- i_wb_ready  in  1  writeback accepts
- o_redirect_valid  out  1  single-cycle fetch redirect
- o_redirect_pc  out  32  redirect target
- o_flush  out  1  kill younger instructions in fetch/decode
- i_csr_done  in  1  CSR file has committed the write
- o_halted  out  1  core halted on ECALL/EBREAK
- i_resume  in  1  leave halt
- o_retired  out  COUNT_W  retired-instruction count

Behaviour:
- Interface: one clock, i_clk. Reset i_rst_n is asynchronous and active-low.
- Reset values:
  - state=RUN, ex_valid=0, flush counter=0, o_retired=0.
  - Hence o_wb_valid=0, o_redirect_valid=0, o_flush=0, o_halted=0, o_dec_ready=1.
- Reset mid-operation (any state) returns to RUN immediately and drops the EX instruction without retiring it.
- States: RUN, FLUSH, CSR_WAIT, HALT.
- o_wb_valid = ex_valid & (state==RUN). Retire = o_wb_valid & i_wb_ready.
- Control event on retire, priority redirect > sys > csr:
  - redirect = i_branch_taken | i_jump
  - sys = i_is_sys & !redirect
  - csr = i_is_csr & !redirect & !i_is_sys
- o_dec_ready, combinational:
  - In RUN: (!ex_valid | (retire & no control event)).
  - In all other states: 0.
- ex_valid next:
  - 1 if o_ex_fire.
  - Else 0 if retire.
  - Else hold.
- Throughput: back-to-back retire and accept in the same cycle gives 1 instruction/cycle. A decode instruction accepted in cycle N is offered to writeback in cycle N+1.
- Redirect (combinational in the retire cycle):
  - o_redirect_valid=1, o_redirect_pc = {i_target[31:1],1'b0}, o_flush=1.
  - Next state FLUSH with counter=FLUSH_CYCLES.
- FLUSH:
  - o_flush=1; counter decrements each cycle.
  - Go to RUN in the cycle after the counter reaches 1.
  - Total o_flush width = FLUSH_CYCLES+1 cycles.
  - i_dec_valid is ignored while in FLUSH.
- CSR_WAIT:
  - Entered on csr retire. i_csr_done is sampled from the next cycle onward; a done in the entry cycle is ignored.
  - On i_csr_done, return to RUN.
- HALT:
  - Entered on sys retire; o_halted=1 while in HALT.
  - i_resume returns to RUN next cycle.
  - i_resume outside HALT has no effect.
- o_retired increments by 1 on every retire, including control-event retires. Wraps modulo 2^COUNT_W with no saturation.
- i_branch_taken, i_jump, i_target, i_is_csr and i_is_sys are don't-care when ex_valid=0.
- i_wb_ready low holds the EX instruction: ex_valid stays 1, no redirect fires, and o_dec_ready=0.

Test Plan:
- Stream: 5 back-to-back ADDs with i_wb_ready=1 -> o_dec_ready stays 1, one retire per cycle, o_retired=5 on the cycle after the last retire, no flush.
- Taken branch: i_branch_taken=1, i_target=0x0000_0105, FLUSH_CYCLES=2 -> in the retire cycle o_redirect_valid=1 and o_redirect_pc=0x0000_0104; o_flush high 3 cycles; o_dec_ready=0 for 3 cycles, then 1.
- Backpressure: i_wb_ready=0 for 4 cycles with a JAL in EX -> no redirect during the hold; redirect in the cycle i_wb_ready rises; o_retired increments once.
- CSR serialisation: CSRRW retires and i_csr_done pulses 3 cycles later -> o_dec_ready=0 for 3 cycles, then a new instruction is accepted.
- Halt: ECALL retires -> o_halted=1 until i_resume; an i_resume pulse before the ECALL is ignored; no fetch redirect.
- Async reset: assert i_rst_n=0 mid-FLUSH with counter=1 -> o_flush=0 immediately, o_retired=0, state RUN after release; set COUNT_W=4 and retire 17 instructions -> o_retired=1.
